fifo_rd_scheduler: RTL and testbench
====================================

FIFO_RD_SCHEDULER -- requirements
Module: fifo_rd_scheduler

Interface
REQ-001 SHALL have parameter DATESIZE, default 8, width of one FIFO data word.
REQ-002 SHALL have parameter NCH, default 4, number of FIFO channels scheduled (2..8).
REQ-003 SHALL have parameter BURST, default 4, maximum words popped per grant (1..15).
REQ-004 SHALL have port clk, input, 1, single clock for all logic (FIFO read-side clock).
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port ch_en, input, NCH, per-channel enable; a disabled channel is never granted.
REQ-007 SHALL have port rempty, input, NCH, per-channel FIFO empty flag.
REQ-008 SHALL have port almost_empty, input, NCH, per-channel FIFO almost-empty flag.
REQ-009 SHALL have port rdata, input, NCH*DATESIZE, packed FIFO read data; channel i at bits [i*DATESIZE +: DATESIZE]; valid combinationally while rempty[i]=0.
REQ-010 SHALL have port rinc, output, NCH, per-channel pop strobe, combinational, at most one bit high per cycle.
REQ-011 SHALL have port out_data, output, DATESIZE, registered output word.
REQ-012 SHALL have port out_ch, output, clog2(NCH) (min 1), source channel of out_data.
REQ-013 SHALL have port out_valid, output, 1, out_data/out_ch hold a word.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts word when out_valid and out_ready both high.
REQ-015 SHALL have port busy, output, 1, high while state is BURST.

Function
REQ-016 SHALL implement FSM states IDLE and BURST.
REQ-017 In IDLE, eligible[i] = ch_en[i] & ~rempty[i]; urgent[i] = eligible[i] & ~almost_empty[i].
REQ-018 In IDLE, if any urgent bit set, SHALL grant the first urgent channel at or after rr_ptr (cyclic); else the first eligible channel at or after rr_ptr; else remain IDLE.
REQ-019 On grant SHALL latch gnt, clear burst counter cnt, enter BURST next cycle; no pop occurs in the granting IDLE cycle.
REQ-020 In BURST, pop = ~rempty[gnt] & ch_en[gnt] & (~out_valid | out_ready); rinc[gnt] = pop; all other rinc bits 0; rinc all 0 in IDLE.
REQ-021 On pop SHALL load out_data <= rdata[gnt], out_ch <= gnt, out_valid <= 1, cnt <= cnt+1.
REQ-022 Without pop, out_valid SHALL clear when out_ready is high, else hold; out_data/out_ch hold while out_valid & ~out_ready.
REQ-023 SHALL leave BURST to IDLE when: a pop with cnt = BURST-1, or rempty[gnt]=1, or ch_en[gnt]=0; on exit rr_ptr <= (gnt+1) mod NCH.
REQ-024 Back-to-back pops SHALL sustain one word per cycle while out_ready stays high; output latency rinc -> out_valid is one cycle.
REQ-025 Backpressure (out_ready=0 with out_valid=1) SHALL stall popping without leaving BURST and without losing or duplicating a word.
REQ-026 The output register SHALL continue draining in IDLE; IDLE-to-BURST costs one dead cycle per grant.
REQ-027 cnt SHALL be 4 bits and never exceed BURST.

Reset
REQ-028 While rst=1 at a clk edge: state IDLE, rr_ptr 0, gnt 0, cnt 0, out_valid 0, out_data 0, out_ch 0, busy 0; rinc SHALL be 0 during any cycle rst=1.
REQ-029 Reset asserted mid-burst SHALL abandon the burst; the word in the output register is discarded; no FIFO pop occurs in that cycle.

Verification
REQ-030 Ch0 holds 6 words (almost_empty=0), others empty, out_ready=1 -> pops 0..3 on cycles 2-5 after IDLE, IDLE one cycle, then pops 4..5; out_ch=0 throughout.
REQ-031 Ch1 and ch2 each hold 2 words, all almost_empty=1, rr_ptr=0 -> ch1 granted first, then ch2; order out_ch 1,1,2,2.
REQ-032 Ch0 holds 1 word (almost_empty=1), ch3 holds 8 (almost_empty=0), rr_ptr=0 -> ch3 granted first.
REQ-033 Ch2 bursting, out_ready low 3 cycles after first word -> rinc held 0, out_data stable, no word lost; words in order after release.
REQ-034 ch_en[1]=0 with ch1 non-empty -> ch1 never granted; deassert ch_en[gnt] mid-burst -> IDLE next cycle.
REQ-035 rst asserted during burst -> next cycle out_valid=0, rinc=0, busy=0, rr_ptr=0.

Source files
------------

// File: rtl/fifo_rd_scheduler.sv
// Read-side scheduler for NCH FIFOs: urgency-aware round-robin grant, bounded
// bursts of pops into a one-deep registered output with ready/valid handshake.
module fifo_rd_scheduler #(
    parameter int DATESIZE = 8,
    parameter int NCH      = 4,
    parameter int BURST    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCH-1:0]            ch_en,
    input  logic [NCH-1:0]            rempty,
    input  logic [NCH-1:0]            almost_empty,
    input  logic [NCH*DATESIZE-1:0]   rdata,
    output logic [NCH-1:0]            rinc,
    output logic [DATESIZE-1:0]       out_data,
    output logic [$clog2(NCH)-1:0]    out_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [0:0]     S_IDLE   = 1'b0;
    localparam logic [0:0]     S_BURST  = 1'b1;
    localparam logic [3:0]     CNT_LAST = 4'(BURST - 1);
    localparam logic [CHW-1:0] CH_LAST  = CHW'(NCH - 1);

    logic [0:0]          state;
    logic [CHW-1:0]      rr_ptr;
    logic [CHW-1:0]      gnt;
    logic [3:0]          cnt;

    logic [NCH-1:0]      eligible;
    logic [NCH-1:0]      urgent;
    logic [CHW:0]        pick_urgent;
    logic [CHW:0]        pick_elig;
    logic [CHW:0]        pick;
    logic [DATESIZE-1:0] words [NCH];
    logic                sel_empty;
    logic                sel_en;
    logic                pop;
    logic                burst_exit;

    // Returns {found, channel} for the first set request at or after ptr,
    // wrapping around; the request vector is doubled so a plain shift rotates it.
    function automatic logic [CHW:0] rr_pick(input logic [NCH-1:0] req,
                                             input logic [CHW-1:0] ptr);
        logic [2*NCH-1:0] rot;
        logic [CHW:0]     sum;
        logic [CHW:0]     res;
        rot = {req, req} >> ptr;
        sum = '0;
        res = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (CHW+1)'(k);
                if (sum >= (CHW+1)'(NCH)) begin
                    sum = sum - (CHW+1)'(NCH);
                end
                res = {1'b1, sum[CHW-1:0]};
            end
        end
        return res;
    endfunction

    always_comb begin
        eligible    = ch_en & ~rempty;
        urgent      = eligible & ~almost_empty;
        pick_urgent = rr_pick(urgent, rr_ptr);
        pick_elig   = rr_pick(eligible, rr_ptr);
        pick        = pick_urgent[CHW] ? pick_urgent : pick_elig;
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            words[i] = rdata[i*DATESIZE +: DATESIZE];
        end
    end

    always_comb begin
        sel_empty  = rempty[gnt];
        sel_en     = ch_en[gnt];
        pop        = ~rst & (state == S_BURST) & ~sel_empty & sel_en
                     & (~out_valid | out_ready);
        burst_exit = (state == S_BURST)
                     & ((pop & (cnt == CNT_LAST)) | sel_empty | ~sel_en);
    end

    always_comb begin
        rinc = '0;
        if (pop) begin
            rinc[gnt] = 1'b1;
        end
    end

    assign busy = (state == S_BURST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            gnt    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick[CHW]) begin
                        gnt   <= pick[CHW-1:0];
                        cnt   <= '0;
                        state <= S_BURST;
                    end
                end
                default: begin
                    if (pop) begin
                        cnt <= cnt + 4'd1;
                    end
                    if (burst_exit) begin
                        state  <= S_IDLE;
                        rr_ptr <= (gnt == CH_LAST) ? '0 : gnt + CHW'(1);
                    end
                end
            endcase
        end
    end

    // Output register stage: one word of storage, loaded only on a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= words[gnt];
            out_ch    <= gnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rd_scheduler.sv
// Bench for fifo_rd_scheduler: FIFO models, rule-level reference model,
// per-channel scoreboard, grant table and directed burst/backpressure/reset sequences.
module tb_fifo_rd_scheduler;

    localparam int NCH   = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;
    localparam int AE_TH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    ch_en;
    logic [NCH-1:0]    rempty;
    logic [NCH-1:0]    almost_empty;
    logic [NCH*DW-1:0] rdata;
    logic [NCH-1:0]    rinc;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_ch;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    always #5 clk = ~clk;

    fifo_rd_scheduler #(.DATESIZE(DW), .NCH(NCH), .BURST(BURST)) dut (
        .clk(clk), .rst(rst), .ch_en(ch_en), .rempty(rempty),
        .almost_empty(almost_empty), .rdata(rdata), .rinc(rinc),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] mem [NCH][256];
    int head [NCH];
    int tail [NCH];
    int acc_head [NCH];

    // reference model state
    logic       m_busy = 1'b0;
    logic       m_ov = 1'b0;
    logic [7:0] m_od = '0;
    logic [1:0] m_oc = '0;
    int         m_gnt = 0;
    int         m_cnt = 0;
    int         m_ptr = 0;

    // values seen at the last sampling edge
    logic [NCH-1:0] s_rinc;
    logic           s_busy, s_ov, s_ready;
    logic [7:0]     s_od;
    logic [1:0]     s_oc;

    typedef struct packed {
        logic [3:0] en;
        logic [4:0] c3, c2, c1, c0;
        logic [3:0] exp_rinc;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NCH; i++) begin
            rempty[i]       = (head[i] == tail[i]);
            almost_empty[i] = ((tail[i] - head[i]) <= AE_TH);
            rdata[i*DW +: DW] = (head[i] != tail[i]) ? mem[i][head[i] % 256] : '0;
        end
    endtask

    task automatic push(input int ch, input logic [7:0] v);
        mem[ch][tail[ch] % 256] = v;
        tail[ch]++;
        refresh();
    endtask

    // One clock: check DUT against the model at negedge, then advance model and FIFOs.
    task automatic step();
        logic [NCH-1:0] c_empty, c_ae, c_en, exp_rinc;
        logic c_rst, c_ready, c_pop, was_busy, leave;
        int found;
        @(negedge clk);
        c_rst   = rst;
        c_en    = ch_en;
        c_ready = out_ready;
        for (int i = 0; i < NCH; i++) begin
            c_empty[i] = (head[i] == tail[i]);
            c_ae[i]    = ((tail[i] - head[i]) <= AE_TH);
        end
        c_pop = !c_rst && m_busy && !c_empty[m_gnt] && c_en[m_gnt] && (!m_ov || c_ready);
        exp_rinc = c_pop ? NCH'(1 << m_gnt) : '0;
        chk("rinc", 32'(rinc), 32'(exp_rinc));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_data", 32'(out_data), 32'(m_od));
        chk("out_ch", 32'(out_ch), 32'(m_oc));
        if (!c_rst && out_valid && out_ready) begin
            chk("order", 32'(out_data), 32'(mem[out_ch][acc_head[out_ch] % 256]));
            acc_head[out_ch]++;
        end
        s_rinc = rinc; s_busy = busy; s_ov = out_valid; s_od = out_data;
        s_oc = out_ch; s_ready = out_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (c_rst) begin
            m_busy = 0; m_ov = 0; m_od = '0; m_oc = '0; m_gnt = 0; m_cnt = 0; m_ptr = 0;
            for (int i = 0; i < NCH; i++) acc_head[i] = head[i];
        end else begin
            was_busy = m_busy;
            leave = was_busy && ((c_pop && m_cnt == BURST - 1) || c_empty[m_gnt] || !c_en[m_gnt]);
            if (c_pop) begin
                m_od = mem[m_gnt][head[m_gnt] % 256];
                m_oc = 2'(m_gnt);
                m_ov = 1'b1;
                head[m_gnt]++;
                m_cnt++;
            end else if (c_ready) begin
                m_ov = 1'b0;
            end
            if (leave) begin
                m_busy = 1'b0;
                m_ptr  = (m_gnt + 1) % NCH;
            end else if (!was_busy) begin
                found = -1;
                for (int k = 0; k < NCH; k++) begin
                    int c;
                    c = (m_ptr + k) % NCH;
                    if (found < 0 && c_en[c] && !c_empty[c] && !c_ae[c]) found = c;
                end
                for (int k = 0; k < NCH; k++) begin
                    int c;
                    c = (m_ptr + k) % NCH;
                    if (found < 0 && c_en[c] && !c_empty[c]) found = c;
                end
                if (found >= 0) begin
                    m_busy = 1'b1;
                    m_gnt  = found;
                    m_cnt  = 0;
                end
            end
        end
        refresh();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        for (int i = 0; i < NCH; i++) begin
            head[i] = 0; tail[i] = 0; acc_head[i] = 0;
        end
        rst = 1'b0;
        out_ready = 1'b1;
        ch_en = '1;
        refresh();
    endtask

    initial begin
        logic [9:0] hist_r, hist_b;
        logic [7:0] ordr;
        logic [7:0] v [6];
        logic [4:0] cc [4];
        logic any_r, any_b;
        int n;

        rst = 1'b1; ch_en = '0; out_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            head[i] = 0; tail[i] = 0; acc_head[i] = 0;
        end
        refresh();

        tbl[0] = '{4'hF,   5'd0, 5'd0, 5'd0, 5'd0, 4'b0000};
        tbl[1] = '{4'hF,   5'd0, 5'd0, 5'd0, 5'd3, 4'b0001};
        tbl[2] = '{4'hF,   5'd8, 5'd0, 5'd0, 5'd1, 4'b1000};
        tbl[3] = '{4'hF,   5'd0, 5'd2, 5'd2, 5'd0, 4'b0010};
        tbl[4] = '{4'b1101, 5'd0, 5'd0, 5'd5, 5'd0, 4'b0000};
        tbl[5] = '{4'hF,   5'd0, 5'd0, 5'd1, 5'd1, 4'b0001};
        tbl[6] = '{4'hF,   5'd1, 5'd0, 5'd1, 5'd0, 4'b0010};
        tbl[7] = '{4'b1011, 5'd5, 5'd5, 5'd0, 5'd0, 4'b1000};
        tbl[8] = '{4'hF,   5'd2, 5'd5, 5'd0, 5'd1, 4'b0100};
        tbl[9] = '{4'h0,   5'd3, 5'd3, 5'd3, 5'd3, 4'b0000};

        // reset state
        do_reset();
        step();
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_valid", 32'(s_ov), 32'd0);
        chk("rst_data", 32'(s_od), 32'd0);
        chk("rst_ch", 32'(s_oc), 32'd0);
        chk("rst_rinc", 32'(s_rinc), 32'd0);

        // grant selection table, each from a fresh reset (rr_ptr = 0)
        for (int t = 0; t < 10; t++) begin
            do_reset();
            ch_en = tbl[t].en;
            cc[0] = tbl[t].c0; cc[1] = tbl[t].c1; cc[2] = tbl[t].c2; cc[3] = tbl[t].c3;
            for (int i = 0; i < NCH; i++)
                for (int j = 0; j < int'(cc[i]); j++) push(i, 8'($urandom));
            step();
            chk("tbl_idle", 32'(s_busy), 32'd0);
            step();
            chk($sformatf("tbl%0d_grant", t), 32'(s_rinc), 32'(tbl[t].exp_rinc));
        end

        // six words on ch0: burst of four, one dead idle cycle, then two more
        do_reset();
        for (int j = 0; j < 6; j++) push(0, 8'(j + 8'h30));
        hist_r = '0; hist_b = '0;
        for (int c = 0; c < 10; c++) begin
            step();
            hist_r[c] = s_rinc[0];
            hist_b[c] = s_busy;
        end
        chk("burst6_pops", 32'(hist_r), 32'(10'b0011011110));
        chk("burst6_busy", 32'(hist_b), 32'(10'b0111011110));

        // ch1 and ch2 two words each, all almost empty: order 1,1,2,2
        do_reset();
        for (int j = 0; j < 2; j++) begin
            push(1, 8'($urandom));
            push(2, 8'($urandom));
        end
        ordr = '0; n = 0;
        for (int c = 0; c < 14; c++) begin
            step();
            if (s_ov && s_ready && n < 4) begin
                ordr[2*n +: 2] = s_oc;
                n++;
            end
        end
        chk("rr_count", 32'(n), 32'd4);
        chk("rr_order", 32'(ordr), 32'(8'hA5));

        // backpressure on ch2 for three cycles after the first word
        do_reset();
        for (int j = 0; j < 6; j++) begin
            v[j] = 8'($urandom);
            push(2, v[j]);
        end
        step();
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp_rinc", 32'(s_rinc), 32'd0);
            chk("bp_hold", 32'(s_od), 32'(v[0]));
            chk("bp_busy", 32'(s_busy), 32'd1);
        end
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (s_ov && s_ready && n < 6) begin
                chk("bp_word", 32'(s_od), 32'(v[n]));
                n++;
            end
        end
        chk("bp_count", 32'(n), 32'd6);

        // disabled channel never granted; disabling the granted channel ends the burst
        do_reset();
        ch_en = 4'b1101;
        for (int j = 0; j < 5; j++) push(1, 8'($urandom));
        any_r = 1'b0; any_b = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            any_r |= s_rinc[1];
            any_b |= s_busy;
        end
        chk("dis_rinc", 32'(any_r), 32'd0);
        chk("dis_busy", 32'(any_b), 32'd0);
        ch_en = 4'hF;
        step();
        step();
        chk("en_pop", 32'(s_rinc), 32'b0010);
        ch_en = 4'b1101;
        step();
        chk("en_drop_rinc", 32'(s_rinc), 32'd0);
        step();
        chk("en_drop_idle", 32'(s_busy), 32'd0);

        // reset mid-burst on ch2 after a ch1 burst moved rr_ptr to 2
        do_reset();
        for (int j = 0; j < 4; j++) push(1, 8'($urandom));
        for (int c = 0; c < 6; c++) step();
        for (int j = 0; j < 8; j++) push(2, 8'($urandom));
        step();
        step();
        chk("pre_rst_pop", 32'(s_rinc), 32'b0100);
        step();
        rst = 1'b1;
        step();
        chk("rst_mid_rinc", 32'(s_rinc), 32'd0);
        rst = 1'b0;
        for (int j = 0; j < 4; j++) push(1, 8'($urandom));
        step();
        chk("rst_mid_valid", 32'(s_ov), 32'd0);
        chk("rst_mid_busy", 32'(s_busy), 32'd0);
        chk("rst_mid_rinc2", 32'(s_rinc), 32'd0);
        step();
        chk("rst_ptr", 32'(s_rinc), 32'b0010);

        // randomized traffic against the model and scoreboard
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            if (c % 60 == 0) ch_en = 4'($urandom_range(0, 15));
            if ($urandom % 2 == 1) begin
                int ch;
                ch = int'($urandom % NCH);
                if (tail[ch] - head[ch] < 20) push(ch, 8'($urandom));
            end
            out_ready = ($urandom % 4) != 0;
            rst = ($urandom % 400) == 0;
            step();
        end

        // drain everything
        rst = 1'b0;
        ch_en = 4'hF;
        out_ready = 1'b1;
        for (int c = 0; c < 250; c++) step();
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("drain_pop%0d", i), 32'(head[i]), 32'(tail[i]));
            chk($sformatf("drain_acc%0d", i), 32'(acc_head[i]), 32'(head[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
